ifmap_row_packer: RTL
=====================

IFMAP_ROW_PACKER -- requirements
Module: ifmap_row_packer

Interface
REQ-001 SHALL have parameter IFMap_WIDTH, default 16, meaning width of one IFMap sample.
REQ-002 SHALL have parameter LEN_WIDTH, default 4, meaning width of the row-length and row-count fields.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rstn, input, 1, meaning reset; it is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, meaning a one-cycle pulse that latches the configuration and begins a frame.
REQ-006 SHALL have port row_len, input, LEN_WIDTH, meaning samples per row; it is sampled only on an accepted start.
REQ-007 SHALL have port num_rows, input, LEN_WIDTH, meaning rows per frame; it is sampled only on an accepted start.
REQ-008 SHALL have port s_data, input, IFMap_WIDTH, meaning the raw signed sample from upstream.
REQ-009 SHALL have port s_valid, input, 1, meaning s_data is valid.
REQ-010 SHALL have port s_ready, output, 1, meaning the block accepts s_data in this cycle.
REQ-011 SHALL have port IFMap, output, IFMap_WIDTH+2, meaning the tagged word {sor, eor, data} sent to the Conv IF buffer.
REQ-012 SHALL have port IF_buff_wen, output, 1, meaning IFMap is valid.
REQ-013 SHALL have port IF_buff_ready, input, 1, meaning the IF buffer accepts a word in this cycle.
REQ-014 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-015 SHALL have port done, output, 1, meaning a one-cycle pulse after the last word of the frame is written.

Function
REQ-016 SHALL provide states IDLE, RUN and FLUSH.
REQ-017 SHALL accept start only in IDLE and SHALL ignore start in RUN or FLUSH.
REQ-018 SHALL, on start in IDLE with row_len!=0 and num_rows!=0, latch both values, clear the column and row counters, and enter RUN.
REQ-019 SHALL, on start with row_len==0 or num_rows==0, stay in IDLE, emit no words, and pulse done in the next cycle.
REQ-020 SHALL drive s_ready = (state==RUN) && (!IF_buff_wen || IF_buff_ready).
REQ-021 SHALL define a sample transfer as s_valid && s_ready, and SHALL register it into IFMap with IF_buff_wen=1 one cycle later.
REQ-022 SHALL define a word write as IF_buff_wen && IF_buff_ready; IF_buff_wen and IFMap SHALL be held stable until a write occurs.
REQ-023 SHALL set sor (bit IFMap_WIDTH+1) on column 0 and eor (bit IFMap_WIDTH) on column row_len-1; a row length of 1 SHALL give flags 2'b11.
REQ-024 SHALL pass the data bits unmodified.
REQ-025 SHALL advance the column counter on each transfer; on the last column it SHALL wrap to 0 and increment the row counter.
REQ-026 SHALL, on the transfer of the last sample of the last row, go to FLUSH with s_ready deasserted.
REQ-027 SHALL, in FLUSH, return to IDLE after the pending word is written and pulse done for exactly one cycle in that cycle.
REQ-028 SHALL, when a write and a new transfer occur in the same cycle, load the new word with no bubble, giving full throughput.
REQ-029 SHALL drive busy high in RUN and FLUSH.

Reset
REQ-030 SHALL, when rstn=0 at a clock edge, set state=IDLE, clear the counters, and drive IFMap=0, IF_buff_wen=0, s_ready=0, busy=0 and done=0.
REQ-031 SHALL, on reset during a frame, drop any pending word without writing it and SHALL NOT pulse done.

Structure
REQ-032 SHALL place the state encoding and the flag constants SOR=2'b10, EOR=2'b01, MID=2'b00 and SOLO=2'b11 in the shared package conv_pkg.
REQ-033 SHALL be a single module with no sub-modules; an optional instance of the shared pipeline-register cell pipe_reg is allowed for the output stage.

Verification
REQ-034 SHALL test one row: row_len=10, num_rows=1, samples 0,0,-1,2,-1,-2,2,0,1,1, IF_buff_ready=1 -> IFMap 0x20000, 0x00000, 0x0FFFF, 0x00002, 0x0FFFF, 0x0FFFE, 0x00002, 0x00000, 0x00001, 0x10001 in 10 consecutive cycles, then done.
REQ-035 SHALL test two rows: row_len=3, num_rows=2, samples 1..6 -> flags 10,00,01,10,00,01 and exactly one done pulse.
REQ-036 SHALL test backpressure: IF_buff_ready low for 3 cycles mid-row -> IFMap and IF_buff_wen held, s_ready=0, and no word lost or duplicated.
REQ-037 SHALL test row_len=1, num_rows=3 -> three words, each with flags 11.
REQ-038 SHALL test the degenerate case: start with row_len=0 -> no IF_buff_wen, and done one cycle later.
REQ-039 SHALL test reset mid-frame: rstn low for 1 cycle after 4 of 10 samples -> all outputs 0, IDLE, no done; a fresh start then completes normally.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end: the row-packer FSM
// state encoding and the row-position flags carried in the top two bits
// of every IFMap word.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Row-position flags {sor, eor}
    localparam logic [1:0] SOR  = 2'b10;
    localparam logic [1:0] EOR  = 2'b01;
    localparam logic [1:0] MID  = 2'b00;
    localparam logic [1:0] SOLO = 2'b11;

    // Map first/last-column status of a sample to its flag pair
    function automatic logic [1:0] row_flags(input logic first, input logic last);
        logic [1:0] flags;
        // NOTE: give every path a value so the combinational result never
        // depends on a previous evaluation (no latch, no stale value).
        flags = MID;
        if (first && last) flags = SOLO;
        else if (first)    flags = SOR;
        else if (last)     flags = EOR;
        return flags;
    endfunction

endpackage

// File: rtl/ifmap_row_packer.sv
// Packs a stream of raw IFMap samples into tagged words {sor, eor, data}
// for the Conv IF buffer. A frame is num_rows rows of row_len samples;
// the first and last column of each row are flagged. The output stage is
// a single register that refills in the same cycle it drains, so a
// ready buffer sees one word per cycle.
module ifmap_row_packer
    import conv_pkg::*;
#(
    parameter int IFMap_WIDTH = 16,
    parameter int LEN_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic [LEN_WIDTH-1:0]   row_len,
    input  logic [LEN_WIDTH-1:0]   num_rows,
    input  logic [IFMap_WIDTH-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [IFMap_WIDTH+1:0] IFMap,
    output logic                   IF_buff_wen,
    input  logic                   IF_buff_ready,
    output logic                   busy,
    output logic                   done
);

    state_t               state;
    logic [LEN_WIDTH-1:0] row_len_q;
    logic [LEN_WIDTH-1:0] num_rows_q;
    logic [LEN_WIDTH-1:0] col;
    logic [LEN_WIDTH-1:0] row;

    logic transfer;
    logic write;
    logic last_col;
    logic last_row;

    // Accept a sample only while running and the output register is free
    // or draining this cycle; this is what gives bubble-free throughput.
    assign s_ready  = (state == RUN) && (!IF_buff_wen || IF_buff_ready);
    assign transfer = s_valid && s_ready;
    assign write    = IF_buff_wen && IF_buff_ready;
    assign last_col = (col == row_len_q - LEN_WIDTH'(1));
    assign last_row = (row == num_rows_q - LEN_WIDTH'(1));
    assign busy     = (state != IDLE);

    // Frame FSM, row/column counters and the registered output word
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: non-blocking assignments throughout, so every register
            // here sees the pre-edge values of the others.
            state       <= IDLE;
            row_len_q   <= '0;
            num_rows_q  <= '0;
            col         <= '0;
            row         <= '0;
            IFMap       <= '0;
            IF_buff_wen <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;

            // Output stage: a new transfer overwrites the word being written
            // in this same cycle; otherwise the word is held until written.
            if (transfer) begin
                IFMap       <= {row_flags(col == '0, last_col), s_data};
                IF_buff_wen <= 1'b1;
            end else if (write) begin
                IF_buff_wen <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (row_len == '0 || num_rows == '0) begin
                            // Empty frame: nothing to send, report completion
                            done <= 1'b1;
                        end else begin
                            row_len_q  <= row_len;
                            num_rows_q <= num_rows;
                            col        <= '0;
                            row        <= '0;
                            state      <= RUN;
                        end
                    end
                end

                RUN: begin
                    if (transfer) begin
                        if (last_col) begin
                            col <= '0;
                            if (last_row) state <= FLUSH;
                            else          row   <= row + LEN_WIDTH'(1);
                        end else begin
                            col <= col + LEN_WIDTH'(1);
                        end
                    end
                end

                FLUSH: begin
                    // Wait for the final word to leave before reporting done
                    if (write || !IF_buff_wen) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
